// File: rtl/tc_pl_cap_pkg.sv
// rtl/tc_pl_cap_pkg.sv - shared types and trailer layout for the PL capture CRC scheduler
// Holds the scheduler state enum, channel-id width and trailer field positions.
package tc_pl_cap_pkg;

   localparam int CH_ID_W = 4;

   localparam logic [7:0] TRL_MARKER = 8'hC5;

   localparam int TRL_MARK_LSB = 56;
   localparam int TRL_CH_LSB   = 52;
   localparam int TRL_OVF_BIT  = 51;
   localparam int TRL_CNT_LSB  = 32;
   localparam int TRL_CRC_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DATA     = 2'd1,
      WAIT_CRC = 2'd2,
      TRAILER  = 2'd3
   } state_t;

   function automatic logic [63:0] pack_trailer(
      input logic [CH_ID_W-1:0] ch,
      input logic               ovf,
      input logic [15:0]        cnt,
      input logic [31:0]        crc
   );
      logic [63:0] t;
      t = '0;
      t[TRL_MARK_LSB +: 8]       = TRL_MARKER;
      t[TRL_CH_LSB +: CH_ID_W]   = ch;
      t[TRL_OVF_BIT]             = ovf;
      t[TRL_CNT_LSB +: 16]       = cnt;
      t[TRL_CRC_LSB +: 32]       = crc;
      return t;
   endfunction

endpackage

// File: rtl/tc_pl_cap_rr_arb.sv
// rtl/tc_pl_cap_rr_arb.sv - combinational round-robin channel pick
// Returns the first requester strictly after last_grant, wrapping to the lowest requester.
module tc_pl_cap_rr_arb
   import tc_pl_cap_pkg::*;
#(
   parameter int CH_NUM = 8
) (
   input  logic [CH_NUM-1:0]  req,
   input  logic [CH_ID_W-1:0] last_grant,
   output logic [CH_ID_W-1:0] grant,
   output logic               any_req
);

   logic               found_hi;
   logic               found_lo;
   logic [CH_ID_W-1:0] grant_hi;
   logic [CH_ID_W-1:0] grant_lo;

   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      grant_hi = '0;
      grant_lo = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (req[c] && !found_lo) begin
            found_lo = 1'b1;
            grant_lo = CH_ID_W'(c);
         end
         if (req[c] && !found_hi && (CH_ID_W'(c) > last_grant)) begin
            found_hi = 1'b1;
            grant_hi = CH_ID_W'(c);
         end
      end
      any_req = found_lo;
      grant   = found_hi ? grant_hi : grant_lo;
   end

endmodule

// File: rtl/tc_pl_cap_crc_sched.sv
// rtl/tc_pl_cap_crc_sched.sv - round-robin frame scheduler feeding the 64-bit CRC32 engine
// Optional frame/overflow statistics are built when CAP_CRC_STAT_EN is defined.
module tc_pl_cap_crc_sched
   import tc_pl_cap_pkg::*;
#(
   parameter int CH_NUM    = 8,
   parameter int CRC_LAT   = 1,
   parameter int FRAME_MAX = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CH_NUM-1:0]      s_valid,
   output logic [CH_NUM-1:0]      s_ready,
   input  logic [CH_NUM*64-1:0]   s_data,
   input  logic [CH_NUM-1:0]      s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [63:0]            m_data,
   output logic                   m_last,
   output logic                   crc_en,
   output logic [63:0]            crc_data,
   output logic                   crc_data_valid,
   input  logic [31:0]            crc32,
   output logic                   busy,
   output logic [CH_ID_W-1:0]     cur_ch,
   output logic [31:0]            frame_cnt,
   output logic [15:0]            ovf_cnt
);

   localparam logic [15:0]        CNT_CAP  = 16'(FRAME_MAX - 1);
   localparam logic [2:0]         WAIT_END = 3'(CRC_LAT - 1);
   localparam logic [CH_ID_W-1:0] LG_RST   = CH_ID_W'(CH_NUM - 1);

   state_t             state;
   logic [CH_ID_W-1:0] grant_q;
   logic [CH_ID_W-1:0] last_grant;
   logic [CH_ID_W-1:0] arb_grant;
   logic               arb_any;
   logic [15:0]        word_cnt;
   logic               ovf;
   logic [2:0]         wait_cnt;
   logic [63:0]        trailer;

   logic               sel_valid;
   logic               sel_last;
   logic [63:0]        sel_data;
   logic               xfer;

   tc_pl_cap_rr_arb #(.CH_NUM(CH_NUM)) u_arb (
      .req        (s_valid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (arb_any)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      s_ready   = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (grant_q == CH_ID_W'(c)) begin
            sel_valid  = s_valid[c];
            sel_last   = s_last[c];
            sel_data   = s_data[64*c +: 64];
            s_ready[c] = (state == DATA) && m_ready;
         end
      end
   end

   // Payload is a combinational passthrough; only the trailer is registered.
   always_comb begin
      m_valid        = 1'b0;
      m_data         = '0;
      m_last         = 1'b0;
      crc_data       = '0;
      crc_data_valid = 1'b0;
      case (state)
         DATA: begin
            m_valid        = sel_valid;
            m_data         = sel_data;
            crc_data       = sel_data;
            crc_data_valid = sel_valid && m_ready;
         end
         TRAILER: begin
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = trailer;
         end
         default: ;
      endcase
   end

   assign xfer   = (state == DATA) && sel_valid && m_ready;
   assign crc_en = (state != IDLE);
   assign busy   = (state != IDLE);
   assign cur_ch = grant_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_q    <= '0;
         last_grant <= LG_RST;
         word_cnt   <= '0;
         ovf        <= 1'b0;
         wait_cnt   <= '0;
         trailer    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_any) begin
                  grant_q <= arb_grant;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  word_cnt <= word_cnt + 16'd1;
                  if (sel_last || (word_cnt == CNT_CAP)) begin
                     ovf      <= (word_cnt == CNT_CAP);
                     wait_cnt <= '0;
                     state    <= WAIT_CRC;
                  end
               end
            end
            WAIT_CRC: begin
               if (wait_cnt == WAIT_END) begin
                  trailer <= pack_trailer(grant_q, ovf, word_cnt, crc32);
                  state   <= TRAILER;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            TRAILER: begin
               if (m_ready) begin
                  last_grant <= grant_q;
                  word_cnt   <= '0;
                  ovf        <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CAP_CRC_STAT_EN
   logic [31:0] frame_q;
   logic [15:0] ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= '0;
         ovf_q   <= '0;
      end else if ((state == TRAILER) && m_ready) begin
         frame_q <= frame_q + 32'd1;
         if (ovf && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
         end
      end
   end

   assign frame_cnt = frame_q;
   assign ovf_cnt   = ovf_q;
`else
   assign frame_cnt = '0;
   assign ovf_cnt   = '0;
`endif

endmodule

// File: tb/tb_tc_pl_cap_crc_sched.sv
// tb/tb_tc_pl_cap_crc_sched.sv - self-checking bench for the capture CRC frame scheduler
// Frame-level model with a stub CRC engine; statistics expectations follow CAP_CRC_STAT_EN.
module tb_tc_pl_cap_crc_sched;

   localparam int CH   = 8;
   localparam int LAT  = 2;
   localparam int FMAX = 4;

`ifdef CAP_CRC_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [CH-1:0]     s_valid;
   logic [CH-1:0]     s_ready;
   logic [CH*64-1:0]  s_data;
   logic [CH-1:0]     s_last;
   logic              m_valid;
   logic              m_ready;
   logic [63:0]       m_data;
   logic              m_last;
   logic              crc_en;
   logic [63:0]       crc_data;
   logic              crc_data_valid;
   logic [31:0]       crc32;
   logic              busy;
   logic [3:0]        cur_ch;
   logic [31:0]       frame_cnt;
   logic [15:0]       ovf_cnt;

   tc_pl_cap_crc_sched #(.CH_NUM(CH), .CRC_LAT(LAT), .FRAME_MAX(FMAX)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_last         (s_last),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_last         (m_last),
      .crc_en         (crc_en),
      .crc_data       (crc_data),
      .crc_data_valid (crc_data_valid),
      .crc32          (crc32),
      .busy           (busy),
      .cur_ch         (cur_ch),
      .frame_cnt      (frame_cnt),
      .ovf_cnt        (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [64:0] chq [CH][$];
   logic [64:0] mq  [CH][$];
   logic [64:0] exp_q[$];
   logic [63:0] trl_log[$];

   logic [31:0] crc_key = 32'h0;
   logic [31:0] crc_acc = 32'h0;
   bit          bp_mode = 1'b0;
   int          m_lastg = CH - 1;
   int          m_frames = 0;
   int          m_ovf = 0;
   int          pay_seen = 0;
   int          dv_pulses = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] mk(input int ch, input int i);
      return {16'(ch) | 16'hB000, 16'(i), 32'hC0DE_0000 ^ 32'(ch * 256 + i * 7 + 1)};
   endfunction

   task automatic push_word(input int ch, input logic [63:0] w, input logic last);
      chq[ch].push_back({last, w});
      mq[ch].push_back({last, w});
   endtask

   // Drains the model queues into the expected output stream, frame by frame, in grant order.
   task automatic model_run();
      logic [64:0] e;
      int          c, d, cnt;
      logic [31:0] x;
      logic        ov;
      bit          more;
      more = 1'b1;
      while (more) begin
         c = -1;
         for (int k = 1; k <= CH; k++) begin
            d = (m_lastg + k) % CH;
            if (c < 0 && mq[d].size() > 0) c = d;
         end
         if (c < 0) begin
            more = 1'b0;
         end else begin
            cnt = 0;
            x   = '0;
            do begin
               e = mq[c].pop_front();
               exp_q.push_back({1'b0, e[63:0]});
               x = x ^ e[31:0] ^ e[63:32];
               cnt++;
            end while (!e[64] && cnt < FMAX && mq[c].size() > 0);
            ov = (cnt == FMAX);
            exp_q.push_back({1'b1, 8'hC5, 4'(c), ov, 3'b000, 16'(cnt), x ^ crc_key});
            m_frames++;
            if (ov) m_ovf++;
            m_lastg = c;
         end
      end
   endtask

   task automatic flush_all();
      for (int c = 0; c < CH; c++) begin
         chq[c].delete();
         mq[c].delete();
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      trl_log.delete();
      m_lastg  = CH - 1;
      m_frames = 0;
      m_ovf    = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      flush_all();
      @(posedge clk); #2;
      rst = 1'b0;
      flush_all();
      model_reset();
   endtask

   function automatic bit src_empty();
      for (int c = 0; c < CH; c++) if (chq[c].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (n < 300 && !(src_empty() && exp_q.size() == 0 && !busy)) begin
         @(negedge clk);
         n++;
      end
      check64({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      check64({name, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic check_stats(input string name);
      check64({name, "_frame_cnt"}, 64'(frame_cnt), STAT ? 64'(m_frames) : 64'd0);
      check64({name, "_ovf_cnt"}, 64'(ovf_cnt), STAT ? 64'(m_ovf) : 64'd0);
   endtask

   task automatic check_zero(input string name);
      check64({name, "_s_ready"}, 64'(s_ready), 64'd0);
      check64({name, "_m_valid"}, 64'(m_valid), 64'd0);
      check64({name, "_m_data"}, m_data, 64'd0);
      check64({name, "_m_last"}, 64'(m_last), 64'd0);
      check64({name, "_crc_en"}, 64'(crc_en), 64'd0);
      check64({name, "_crc_data"}, crc_data, 64'd0);
      check64({name, "_crc_dv"}, 64'(crc_data_valid), 64'd0);
      check64({name, "_busy"}, 64'(busy), 64'd0);
      check64({name, "_cur_ch"}, 64'(cur_ch), 64'd0);
      check64({name, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
      check64({name, "_ovf_cnt"}, 64'(ovf_cnt), 64'd0);
   endtask

   // Source channels, downstream ready and a registered XOR-fold stand-in for the CRC engine.
   logic [CH-1:0] acc_mask;
   logic          smp_rst, smp_fold, smp_en;
   logic [63:0]   smp_fd;
   initial begin
      s_valid = '0;
      s_data  = '0;
      s_last  = '0;
      m_ready = 1'b1;
      crc32   = '0;
      forever begin
         @(negedge clk);
         acc_mask = s_valid & s_ready;
         smp_rst  = rst;
         smp_fold = crc_data_valid;
         smp_fd   = crc_data;
         smp_en   = crc_en;
         @(posedge clk); #1;
         for (int c = 0; c < CH; c++) begin
            if (!smp_rst && acc_mask[c] && chq[c].size() > 0) void'(chq[c].pop_front());
         end
         if (smp_rst || !smp_en) crc_acc = '0;
         else if (smp_fold) crc_acc = crc_acc ^ smp_fd[31:0] ^ smp_fd[63:32];
         crc32 = crc_acc ^ crc_key;
         for (int c = 0; c < CH; c++) begin
            if (chq[c].size() > 0) begin
               s_valid[c]          = 1'b1;
               s_data[64*c +: 64]  = chq[c][0][63:0];
               s_last[c]           = chq[c][0][64];
            end else begin
               s_valid[c]          = 1'b0;
               s_data[64*c +: 64]  = '0;
               s_last[c]           = 1'b0;
            end
         end
         m_ready = bp_mode ? ~m_ready : 1'b1;
      end
   end

   // Output stream checker against the expected queue.
   logic        hold_prev = 1'b0;
   logic [63:0] prev_data;
   logic        prev_last;
   logic [64:0] e_w;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_prev = 1'b0;
         end else begin
            check64("crc_dv", 64'(crc_data_valid), 64'(m_valid && m_ready && !m_last));
            check64("crc_en_busy", 64'(crc_en), 64'(busy));
            if (crc_data_valid) begin
               dv_pulses++;
               check64("crc_data", crc_data, m_data);
            end
            if (hold_prev) begin
               check64("hold_valid", 64'(m_valid), 64'd1);
               check64("hold_data", m_data, prev_data);
               check64("hold_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check64("unexpected_word", m_data, 64'd0);
               end else begin
                  e_w = exp_q.pop_front();
                  check64("m_data", m_data, e_w[63:0]);
                  check64("m_last", 64'(m_last), 64'(e_w[64]));
               end
               if (m_last) trl_log.push_back(m_data);
               else pay_seen++;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   int rr_exp[4] = '{0, 3, 7, 0};
   int n;

   initial begin
      rst = 1'b1;
      do_reset();
      @(negedge clk);
      check_zero("reset");

      // Single frame on ch2; hi==lo words fold to zero so the stub returns the key.
      @(posedge clk); #2;
      crc_key = 32'hDEADBEEF;
      push_word(2, 64'h0102_0304_0102_0304, 1'b0);
      push_word(2, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
      push_word(2, 64'h5555_AAAA_5555_AAAA, 1'b1);
      model_run();
      wait_idle("single");
      check64("single_trl_n", 64'(trl_log.size()), 64'd1);
      check64("single_trailer", trl_log[0], 64'hC520_0003_DEADBEEF);
      check_stats("single");

      // Round-robin across ch0 (two frames), ch3, ch7.
      do_reset();
      @(posedge clk); #2;
      crc_key = 32'h1357_9BDF;
      push_word(0, mk(0, 0), 1'b1);
      push_word(0, mk(0, 1), 1'b1);
      push_word(3, mk(3, 0), 1'b1);
      push_word(7, mk(7, 0), 1'b1);
      model_run();
      wait_idle("rr");
      check64("rr_trl_n", 64'(trl_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) check64($sformatf("rr_order%0d", i), 64'(trl_log[i][55:52]), 64'(rr_exp[i]));
      check_stats("rr");

      // Overflow: 6 words on ch1 against FRAME_MAX=4.
      do_reset();
      @(posedge clk); #2;
      crc_key = 32'h0BAD_F00D;
      for (int i = 0; i < 6; i++) push_word(1, mk(1, i), i == 5);
      model_run();
      wait_idle("ovf");
      check64("ovf_trl_n", 64'(trl_log.size()), 64'd2);
      check64("ovf_trl1_hi", 64'(trl_log[0][63:32]), 64'hC518_0004);
      check64("ovf_trl2_hi", 64'(trl_log[1][63:32]), 64'hC510_0002);
      check_stats("ovf");

      // Backpressure: m_ready toggles during a 3-word frame and its trailer.
      @(posedge clk); #2;
      trl_log.delete();
      dv_pulses = 0;
      bp_mode   = 1'b1;
      crc_key   = 32'h2468_ACE0;
      for (int i = 0; i < 3; i++) push_word(5, mk(5, i), i == 2);
      model_run();
      wait_idle("bp");
      bp_mode = 1'b0;
      check64("bp_dv_pulses", 64'(dv_pulses), 64'd3);
      check64("bp_trl_n", 64'(trl_log.size()), 64'd1);
      check_stats("bp");

      // Reset after word 2 of a 5-word frame on ch0.
      @(posedge clk); #2;
      pay_seen = 0;
      crc_key  = 32'h0F0F_1234;
      for (int i = 0; i < 5; i++) push_word(0, mk(0, 10 + i), i == 4);
      model_run();
      n = 0;
      while (pay_seen < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check64("rst_wait", 64'(pay_seen >= 2), 64'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      flush_all();
      @(posedge clk); #2;
      rst = 1'b0;
      flush_all();
      model_reset();
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk); #2;
      push_word(0, mk(0, 20), 1'b0);
      push_word(0, mk(0, 21), 1'b1);
      model_run();
      wait_idle("post_rst");
      check64("post_rst_trl_n", 64'(trl_log.size()), 64'd1);
      check64("post_rst_trl_hi", 64'(trl_log[0][63:32]), 64'hC500_0002);
      check_stats("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
